// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline sequencing controller
package pipe_ctrl_pkg;
    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;
    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_TRAP = 2'b01;
    localparam logic [1:0] PCSEL_EPC = 2'b10;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_4180;
endpackage

// File: rtl/pipe_ctrl_md_busy_cnt.sv
// md_busy_cnt: mult/div busy counter, reloads on an accepted start and counts down to zero
module md_busy_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic md_busy
);
    logic [CNT_W-1:0] cnt;
    assign md_busy = cnt != '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else cnt <= load ? (is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) : cnt - CNT_W'(md_busy);
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall/flush strobes, mult/div busy tracking and trap entry sequencing
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_use_hz,
    input  logic       md_start_E,
    input  logic       md_is_div_E,
    input  logic       md_use_D,
    input  logic       eret_D,
    input  logic       exc_M,
    input  logic       irq,
    output logic       en_PC,
    output logic       en_F_D,
    output logic       en_D_E,
    output logic       en_E_M,
    output logic       en_M_W,
    output logic       clr_F_D,
    output logic       clr_D_E,
    output logic       clr_E_M,
    output logic       clr_M_W,
    output logic [1:0] pc_sel,
    output logic       epc_we,
    output logic       md_busy
);
    state_t state, state_nx;
    logic irq_pend, trap_req, stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            irq_pend <= 1'b0;
        end else begin
            state <= state_nx;
            irq_pend <= irq | (irq_pend & ~trap_req);
        end
    end

    always_comb begin
        {en_PC, en_F_D, en_D_E, en_E_M, en_M_W} = '1;
        {clr_F_D, clr_D_E, clr_E_M, clr_M_W} = '0;
        pc_sel = PCSEL_SEQ;
        epc_we = 1'b0;
        state_nx = RUN;
        trap_req = state == RUN && (exc_M || irq_pend);
        stall = load_use_hz | (md_use_D & (md_busy | md_start_E));
        if (state == TRAP) begin
            pc_sel = PCSEL_TRAP;
            {clr_F_D, clr_D_E, clr_E_M, clr_M_W} = '1;
        end else if (trap_req) begin
            epc_we = 1'b1;
            {clr_F_D, clr_D_E, clr_E_M, clr_M_W} = '1;
            state_nx = TRAP;
        end else if (stall) begin
            {en_PC, en_F_D} = '0;
            clr_D_E = 1'b1;
        end else if (eret_D) begin
            pc_sel = PCSEL_EPC;
            clr_F_D = 1'b1;
        end
    end

    // a start flushed out of E never reaches the unit, so it must not load
    md_busy_cnt #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_cnt (
        .clk(clk),
        .reset(reset),
        .load(md_start_E & en_E_M & ~clr_E_M),
        .is_div(md_is_div_E),
        .md_busy(md_busy)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized run against a cycle-level reference model
module tb_pipe_ctrl;
    logic clk = 0, reset = 0;
    logic load_use_hz = 0, md_start_E = 0, md_is_div_E = 0, md_use_D = 0, eret_D = 0, exc_M = 0, irq = 0;
    logic en_PC, en_F_D, en_D_E, en_E_M, en_M_W, clr_F_D, clr_D_E, clr_E_M, clr_M_W, epc_we, md_busy;
    logic [1:0] pc_sel;
    logic [12:0] obs;
    int checks = 0, errors = 0;

    localparam logic [12:0] V_IDLE = 13'b11111_0000_00_0_0;
    localparam logic [12:0] V_STALL = 13'b00111_0100_00_0_0;
    localparam logic [12:0] V_TREQ = 13'b11111_1111_00_1_0;
    localparam logic [12:0] V_TRAP = 13'b11111_1111_01_0_0;
    localparam logic [12:0] V_ERET = 13'b11111_1000_10_0_0;

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .load_use_hz(load_use_hz), .md_start_E(md_start_E),
        .md_is_div_E(md_is_div_E), .md_use_D(md_use_D), .eret_D(eret_D), .exc_M(exc_M), .irq(irq),
        .en_PC(en_PC), .en_F_D(en_F_D), .en_D_E(en_D_E), .en_E_M(en_E_M), .en_M_W(en_M_W),
        .clr_F_D(clr_F_D), .clr_D_E(clr_D_E), .clr_E_M(clr_E_M), .clr_M_W(clr_M_W),
        .pc_sel(pc_sel), .epc_we(epc_we), .md_busy(md_busy)
    );

    assign obs = {en_PC, en_F_D, en_D_E, en_E_M, en_M_W, clr_F_D, clr_D_E, clr_E_M, clr_M_W, pc_sel, epc_we, md_busy};

    always #5 clk = ~clk;

    // inputs: {load_use_hz, md_start_E, md_is_div_E, md_use_D, eret_D, exc_M, irq}
    task automatic drive(input logic [6:0] v);
        @(negedge clk);
        {load_use_hz, md_start_E, md_is_div_E, md_use_D, eret_D, exc_M, irq} = v;
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        {load_use_hz, md_start_E, md_is_div_E, md_use_D, eret_D, exc_M, irq} = '0;
        reset = 0;
        #2 reset = 1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 0;
        #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL reset_held got %b want %b", obs, V_IDLE); end
        #1 reset = 1;
        drive(7'b0);
        checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL reset_first got %b want %b", obs, V_IDLE); end
    endtask

    task automatic test_load_use;
        do_reset;
        drive(7'b1000000);
        checks++; if (obs !== V_STALL) begin errors++; $display("FAIL load_use got %b want %b", obs, V_STALL); end
        drive(7'b0);
        checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL load_use_after got %b want %b", obs, V_IDLE); end
    endtask

    task automatic test_md(input logic is_div, input int busy_want);
        int busy_n = 0, stall_n = 0;
        do_reset;
        drive({2'b01, is_div, 4'b1000});
        checks++; if (md_busy !== 1'b0 || en_PC !== 1'b0) begin errors++; $display("FAIL md_start div=%0d busy %b en_PC %b want 0 0", is_div, md_busy, en_PC); end
        stall_n += 32'(!en_PC);
        for (int i = 0; i < 15; i++) begin
            drive(7'b0001000);
            busy_n += 32'(md_busy);
            stall_n += 32'(!en_PC);
        end
        checks++; if (busy_n != busy_want) begin errors++; $display("FAIL md_busy_len div=%0d got %0d want %0d", is_div, busy_n, busy_want); end
        checks++; if (stall_n != busy_want + 1) begin errors++; $display("FAIL md_stall_len div=%0d got %0d want %0d", is_div, stall_n, busy_want + 1); end
    endtask

    task automatic test_exc;
        do_reset;
        drive(7'b0110010);
        checks++; if (obs !== V_TREQ) begin errors++; $display("FAIL exc_cycle got %b want %b", obs, V_TREQ); end
        drive(7'b0000010);
        checks++; if (obs !== V_TRAP) begin errors++; $display("FAIL exc_trap got %b want %b", obs, V_TRAP); end
        drive(7'b0);
        checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL exc_run got %b want %b", obs, V_IDLE); end
    endtask

    task automatic test_irq_busy;
        int busy_n = 0;
        do_reset;
        drive(7'b0110000);
        for (int i = 1; i <= 14; i++) begin
            drive(i == 4 ? 7'b0000001 : 7'b0);
            busy_n += 32'(md_busy);
            if (i == 4) begin
                checks++; if (epc_we !== 1'b0) begin errors++; $display("FAIL irq_latency epc_we got %b want 0", epc_we); end
            end
            if (i == 5) begin
                checks++; if (obs !== (V_TREQ | 13'b1)) begin errors++; $display("FAIL irq_treq got %b want %b", obs, V_TREQ | 13'b1); end
            end
            if (i == 6) begin
                checks++; if (obs !== (V_TRAP | 13'b1)) begin errors++; $display("FAIL irq_trap got %b want %b", obs, V_TRAP | 13'b1); end
            end
            if (i == 7) begin
                checks++; if (obs !== (V_IDLE | 13'b1)) begin errors++; $display("FAIL irq_back_run got %b want %b", obs, V_IDLE | 13'b1); end
            end
            if (i == 11) begin
                checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL irq_busy_drop got %b want 0", md_busy); end
            end
        end
        checks++; if (busy_n != 10) begin errors++; $display("FAIL irq_busy_len got %0d want 10", busy_n); end
    endtask

    task automatic test_eret;
        do_reset;
        drive(7'b1000100);
        checks++; if (obs !== V_STALL) begin errors++; $display("FAIL eret_stalled got %b want %b", obs, V_STALL); end
        drive(7'b0000100);
        checks++; if (obs !== V_ERET) begin errors++; $display("FAIL eret_act got %b want %b", obs, V_ERET); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        drive(7'b0110000);
        drive(7'b0000010);
        drive(7'b0);
        checks++; if (obs !== (V_TRAP | 13'b1)) begin errors++; $display("FAIL mid_pre got %b want %b", obs, V_TRAP | 13'b1); end
        reset = 0;
        #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL mid_async got %b want %b", obs, V_IDLE); end
        reset = 1;
        drive(7'b0);
        checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL mid_after got %b want %b", obs, V_IDLE); end
    endtask

    task automatic test_random;
        bit m_trap = 0, m_pend = 0;
        int m_cnt = 0;
        logic [6:0] v;
        logic [12:0] e;
        bit treq, stl, lu, ms, dv, mu, er, ex, iq;
        do_reset;
        for (int n = 0; n < 3000; n++) begin
            lu = $urandom_range(4) == 0; ms = $urandom_range(5) == 0; dv = $urandom_range(1) == 1;
            mu = $urandom_range(2) == 0; er = $urandom_range(7) == 0; ex = $urandom_range(39) == 0;
            iq = $urandom_range(29) == 0;
            v = {lu, ms, dv, mu, er, ex, iq};
            drive(v);
            treq = !m_trap && (ex || m_pend);
            stl = lu || (mu && (m_cnt > 0 || ms));
            if (m_trap) e = V_TRAP;
            else if (treq) e = V_TREQ;
            else if (stl) e = V_STALL;
            else if (er) e = V_ERET;
            else e = V_IDLE;
            e[0] = m_cnt > 0;
            checks++; if (obs !== e) begin errors++; $display("FAIL random n=%0d in=%b got %b want %b", n, v, obs, e); end
            m_cnt = (ms && !m_trap && !treq) ? (dv ? 10 : 5) : (m_cnt > 0 ? m_cnt - 1 : 0);
            m_pend = iq || (m_pend && !treq);
            m_trap = treq;
        end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_md(1'b1, 10);
        test_md(1'b0, 5);
        test_exc;
        test_irq_busy;
        test_eret;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It generates per-stage enable (stall) and clear (flush) strobes for the PC and the F/D, D/E, E/M and M/W pipeline registers. It also tracks the multi-cycle mult/div unit with a busy counter and sequences exception and interrupt entry through a one-cycle TRAP state. It sits beside the hazard detector and CP0, and its outputs drive every pipeline register's enable and clear pins.

## Interface
- MULT_CYCLES, 5, busy cycles loaded on a mult/multu start
- DIV_CYCLES, 10, busy cycles loaded on a div/divu start
- CNT_W, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low; all state clears immediately on assertion
- load_use_hz  in  1  the D-stage instruction reads the rt/rs written by a load currently in E
- md_start_E  in  1  a mult/div instruction is in E this cycle
- md_is_div_E  in  1  qualifies md_start_E: 1 = div, 0 = mult
- md_use_D  in  1  the D-stage instruction is a mult/div/mfhi/mflo/mthi/mtlo
- eret_D  in  1  eret in D
- exc_M  in  1  synchronous exception flagged by the M-stage instruction
- irq  in  1  external interrupt level, already masked by CP0 IE/IM
- en_PC, en_F_D, en_D_E, en_E_M, en_M_W  out  1 each  register enables (1 = load)
- clr_F_D, clr_D_E, clr_E_M, clr_M_W  out  1 each  synchronous clear to a bubble on the next edge
- pc_sel  out  2  00 sequential/branch, 01 trap vector 0x0000_4180, 10 EPC (eret)
- epc_we  out  1  CP0 EPC/Cause write strobe
- md_busy  out  1  mult/div busy counter nonzero

## Operation
- State machine: RUN, TRAP. Separate from it: busy counter `cnt` (CNT_W bits) and pending-interrupt flag `irq_pend`.
- `irq_pend` is set on the clock edge where irq=1. It is cleared on the edge that enters TRAP.
- trap_req = exc_M | irq_pend. It has the highest priority.
- Cycle with trap_req=1:
  - epc_we=1, clr_M_W=1, clr_E_M=1, clr_D_E=1, clr_F_D=1.
  - All enables are 1. pc_sel=00.
  - Next state is TRAP.
- TRAP, exactly one cycle:
  - pc_sel=01, en_PC=1.
  - clr_F_D=1, clr_D_E=1, clr_E_M=1, clr_M_W=1.
  - Next state is always RUN. trap_req is ignored while in TRAP; a pending irq is serviced in the following RUN cycle.
- RUN without trap_req: stall = load_use_hz | (md_use_D & (md_busy | md_start_E)).
  - On stall: en_PC=0, en_F_D=0, clr_D_E=1. Other enables are 1 and other clears are 0.
  - eret_D without stall: pc_sel=10 and clr_F_D=1.
  - eret_D with stall: the eret waits in D and is not acted on.
- Busy counter:
  - If md_start_E and the E/M register advances (en_E_M=1, clr_E_M=0): load DIV_CYCLES or MULT_CYCLES according to md_is_div_E.
  - Otherwise, if cnt≠0: decrement, saturating at 0.
  - The counter keeps running through TRAP, because the unit has already started.
  - A flushed md_start_E (trap cycle) does not load.
  - md_busy = (cnt≠0).

## Timing
- Reset values:
  - state=RUN, cnt=0, irq_pend=0.
  - Outputs: en_*=1, clr_*=0, pc_sel=00, epc_we=0, md_busy=0.
- All outputs are combinational from the registered state plus the current inputs. There is no output register.
- Trap latency:
  - exc_M is acted on in the same cycle.
  - irq asserted at cycle n is latched at edge n+1. trap_req is seen in cycle n+1, the handler PC is loaded at edge n+3, and the first handler fetch occurs at n+3.
- Mult/div stall length:
  - A dependent instruction in D stalls for MULT_CYCLES or DIV_CYCLES cycles after start, plus one for the start cycle itself.
  - A new md_start_E reloads the counter; it does not add to it.
- Simultaneous events:
  - trap_req overrides stall and eret.
  - load_use_hz together with an md stall counts as a single stall.
- Reset asserted mid-operation (TRAP or cnt≠0) returns to the reset values immediately. It does not wait for a clock edge.

## Structure
- Shared package: the state encoding (RUN=0, TRAP=1), the pc_sel encodings (PCSEL_SEQ, PCSEL_TRAP, PCSEL_EPC), and the trap vector constant 32'h0000_4180.
- Natural sub-module: `md_busy_cnt`, which holds the load/decrement counter and md_busy. The FSM and strobe decode remain in pipe_ctrl.

## Test plan
- Reset low, then release → en_*=1, clr_*=0, pc_sel=00, md_busy=0 on the first cycle.
- load_use_hz=1 for 1 cycle → that cycle has en_PC=0, en_F_D=0, clr_D_E=1; the next cycle returns to all enables 1.
- md_start_E=1 with md_is_div_E=1, then md_use_D=1 held → md_busy for exactly 10 cycles and stall for 11 cycles total. Repeat with mult → 5 busy cycles and 6 stall cycles.
- exc_M=1 for one cycle → epc_we=1 with all clr_*=1 that cycle; the next cycle has pc_sel=01 in TRAP; then RUN.
- irq pulse while cnt=7 → trap taken two cycles later, the counter continues decrementing through TRAP, and md_busy drops on schedule.
- eret_D=1 with load_use_hz=1, then load_use_hz=0 → the first cycle is a stall with pc_sel=00; the next cycle has pc_sel=10 and clr_F_D=1.
